game_state_tracker: RTL and testbench

Synchronous game-state controller that turns raw playfield collision levels (ball hit, ball lost) and a start button into a two-digit BCD score, a lives count and a serve/play/game-over sequence. It sits directly upstream of the scoreboard generator: `score0`, `score1` and `lives` drive its digit inputs unchanged. The ball/paddle logic consumes `ball_en`. Everything runs on the pixel clock with frame timing taken from `vsync`.

---
 rtl/game_state_tracker_pkg.sv | 31 +++
 rtl/game_state_tracker_edge_detect.sv | 27 ++
 rtl/game_state_tracker.sv | 169 ++++++++++++++++
 tb/tb_game_state_tracker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_state_tracker_pkg.sv
// Shared definitions for the game state tracker.
//   - state_e     : game phase encoding (IDLE/SERVE/PLAY/OVER)
//   - BCD_MAX     : largest value a BCD digit can hold
//   - DEFAULT_LIVES: lives loaded at game start unless overridden
//   - bcd_inc     : two-digit BCD increment that saturates at 99
package game_state_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX       = 4'd9;
  localparam int         DEFAULT_LIVES = 3;

  // Returns {tens, ones} after one increment; 99 stays 99.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] res;
    if (ones != BCD_MAX) begin
      res = {tens, ones + 4'd1};
    end else if (tens != BCD_MAX) begin
      res = {tens + 4'd1, 4'd0};
    end else begin
      res = {tens, ones};
    end
    return res;
  endfunction

endpackage

// File: rtl/game_state_tracker_edge_detect.sv
// One-bit rising-edge detector.
// Ports:
//   clk_i   : clock
//   reset_i : asynchronous active-high reset, clears the history bit
//   d_i     : level input
//   rise_o  : high for the cycle where d_i is 1 and the previous sample was 0
module edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic rise_o
);

  logic hist_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= d_i;
    end
  end

  // The event is seen on the same edge that first samples d_i high.
  assign rise_o = d_i & ~hist_q;

endmodule

// File: rtl/game_state_tracker.sv
// Game state controller: turns collision levels and a start button into a
// two-digit BCD score, a lives count and an IDLE/SERVE/PLAY/OVER sequence.
// Frame timing comes from rising edges of vsync.
// Ports:
//   clk, reset (async, active-high)
//   vsync, start, hit, miss : level inputs, each edge-detected
//   score0 / score1         : BCD ones / tens digit
//   lives                   : lives remaining (0-9)
//   state                   : IDLE=0, SERVE=1, PLAY=2, OVER=3
//   ball_en                 : high only in PLAY
//   game_over               : high only in OVER
// Optional build macro GAME_STATE_EXTRA_LIFE_EN: one bonus life per game when
// the score crosses 49 -> 50 (lives capped at 9).
module game_state_tracker
  import game_state_tracker_pkg::*;
#(
  parameter int START_LIVES  = DEFAULT_LIVES,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] lives,
  output logic [1:0] state,
  output logic       ball_en,
  output logic       game_over
);

  localparam logic [3:0] LIVES_INIT = 4'(START_LIVES);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);

  logic tick_ev, start_ev, hit_ev, miss_ev;

  edge_detect u_ed_vsync (.clk_i(clk), .reset_i(reset), .d_i(vsync), .rise_o(tick_ev));
  edge_detect u_ed_start (.clk_i(clk), .reset_i(reset), .d_i(start), .rise_o(start_ev));
  edge_detect u_ed_hit   (.clk_i(clk), .reset_i(reset), .d_i(hit),   .rise_o(hit_ev));
  edge_detect u_ed_miss  (.clk_i(clk), .reset_i(reset), .d_i(miss),  .rise_o(miss_ev));

  state_e     state_q, state_d;
  logic [3:0] score0_q, score0_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] lives_q, lives_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] lives_tmp;
  logic [7:0] score_inc;
`ifdef GAME_STATE_EXTRA_LIFE_EN
  logic       award_q, award_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      score0_q <= 4'd0;
      score1_q <= 4'd0;
      lives_q  <= LIVES_INIT;
      cnt_q    <= 8'd0;
`ifdef GAME_STATE_EXTRA_LIFE_EN
      award_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      score0_q <= score0_d;
      score1_q <= score1_d;
      lives_q  <= lives_d;
      cnt_q    <= cnt_d;
`ifdef GAME_STATE_EXTRA_LIFE_EN
      award_q  <= award_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    score0_d  = score0_q;
    score1_d  = score1_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    lives_tmp = lives_q;
    score_inc = bcd_inc(score1_q, score0_q);
`ifdef GAME_STATE_EXTRA_LIFE_EN
    award_d   = award_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          state_d  = ST_SERVE;
          score0_d = 4'd0;
          score1_d = 4'd0;
          lives_d  = LIVES_INIT;
          cnt_d    = 8'd0;
`ifdef GAME_STATE_EXTRA_LIFE_EN
          award_d  = 1'b0;
`endif
        end
      end

      ST_SERVE: begin
        // The tick that reaches the count moves to PLAY on that same edge.
        if (tick_ev) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = ST_PLAY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      ST_PLAY: begin
        if (hit_ev) begin
          {score1_d, score0_d} = score_inc;
`ifdef GAME_STATE_EXTRA_LIFE_EN
          if (!award_q && score1_q == 4'd4 && score0_q == BCD_MAX) begin
            award_d = 1'b1;
            if (lives_tmp != BCD_MAX) lives_tmp = lives_tmp + 4'd1;
          end
`endif
        end
        // A simultaneous hit has already been folded in above, so the miss
        // acts on the post-hit lives value.
        if (miss_ev) begin
          if (lives_tmp != 4'd0) lives_tmp = lives_tmp - 4'd1;
          cnt_d   = 8'd0;
          state_d = (lives_tmp == 4'd0) ? ST_OVER : ST_SERVE;
        end
        lives_d = lives_tmp;
      end

      ST_OVER: begin
        if (start_ev) begin
          state_d  = ST_SERVE;
          score0_d = 4'd0;
          score1_d = 4'd0;
          lives_d  = LIVES_INIT;
          cnt_d    = 8'd0;
`ifdef GAME_STATE_EXTRA_LIFE_EN
          award_d  = 1'b0;
`endif
        end else if (tick_ev) begin
          // Score is left untouched so the last result stays on display.
          if (cnt_q == OVER_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign score0    = score0_q;
  assign score1    = score1_q;
  assign lives     = lives_q;
  assign state     = state_q;
  assign ball_en   = (state_q == ST_PLAY);
  assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_game_state_tracker.sv
module tb_game_state_tracker;

  localparam int START_LIVES  = 3;
  localparam int SERVE_FRAMES = 60;
  localparam int OVER_FRAMES  = 180;
`ifdef GAME_STATE_EXTRA_LIFE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0, start = 1'b0, hit = 1'b0, miss = 1'b0;
  logic [3:0] score0, score1, lives;
  logic [1:0] state;
  logic       ball_en, game_over;

  game_state_tracker #(
    .START_LIVES(START_LIVES), .SERVE_FRAMES(SERVE_FRAMES), .OVER_FRAMES(OVER_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .start(start), .hit(hit), .miss(miss),
    .score0(score0), .score1(score1), .lives(lives), .state(state),
    .ball_en(ball_en), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit rst_val = 1'b1;

  // Reference model: score as an integer 0..99, phases as small integers.
  int m_score, m_lives, m_state, m_cnt;
  bit m_flag;
  bit pv, ps, ph, pm;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_score = 0; m_lives = START_LIVES; m_state = 0; m_cnt = 0; m_flag = 0;
    pv = 0; ps = 0; ph = 0; pm = 0;
  endtask

  task automatic model_new_game();
    m_score = 0; m_lives = START_LIVES; m_cnt = 0; m_state = 1; m_flag = 0;
  endtask

  task automatic model_step();
    bit ev, es, eh, em;
    if (reset) begin
      model_reset();
      return;
    end
    ev = vsync && !pv; es = start && !ps; eh = hit && !ph; em = miss && !pm;
    pv = vsync; ps = start; ph = hit; pm = miss;
    case (m_state)
      0: if (es) model_new_game();
      1: if (ev) begin
        m_cnt++;
        if (m_cnt == SERVE_FRAMES) begin m_state = 2; m_cnt = 0; end
      end
      2: begin
        if (eh) begin
          if (EXTRA == 1 && !m_flag && m_score == 49) begin
            m_flag = 1;
            if (m_lives < 9) m_lives++;
          end
          if (m_score < 99) m_score++;
        end
        if (em) begin
          if (m_lives > 0) m_lives--;
          m_cnt = 0;
          m_state = (m_lives == 0) ? 3 : 1;
        end
      end
      default: if (es) model_new_game();
        else if (ev) begin
          m_cnt++;
          if (m_cnt == OVER_FRAMES) begin m_state = 0; m_cnt = 0; end
        end
    endcase
  endtask

  task automatic check_all();
    check("score0", 8'(score0), 8'(m_score % 10));
    check("score1", 8'(score1), 8'(m_score / 10));
    check("lives", 8'(lives), 8'(m_lives));
    check("state", 8'(state), 8'(m_state));
    check("ball_en", 8'(ball_en), 8'(m_state == 2));
    check("game_over", 8'(game_over), 8'(m_state == 3));
  endtask

  task automatic drive(input bit v, input bit s, input bit h, input bit m);
    @(negedge clk);
    reset = rst_val; vsync = v; start = s; hit = h; miss = m;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // One frame: two low cycles (optional hit noise), then two high cycles quiet.
  task automatic frames(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, noise ? 1'($urandom_range(0, 1)) : 1'b0, 0);
      drive(0, 0, noise ? 1'($urandom_range(0, 1)) : 1'b0, 0);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
    end
  endtask

  task automatic pulse(input bit s, input bit h, input bit m);
    drive(0, s, h, m);
    drive(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    // Reset state
    drive(1, 1, 1, 1);
    drive(0, 0, 0, 0);
    check("rst_state", 8'(state), 8'd0);
    check("rst_lives", 8'(lives), 8'd3);
    check("rst_score", {score1, score0}, 8'h00);
    rst_val = 1'b0;

    // IDLE ignores hits and misses
    for (int i = 0; i < 20; i++) drive(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drive(0, 0, 0, 0);

    // Start -> SERVE, 60 frames -> PLAY
    pulse(1, 0, 0);
    check("start_state", 8'(state), 8'd1);
    check("start_lives", 8'(lives), 8'd3);
    check("start_score", {score1, score0}, 8'h00);
    frames(SERVE_FRAMES - 1, 1);
    check("serve_59", 8'(state), 8'd1);
    frames(1, 1);
    check("serve_60", 8'(state), 8'd2);
    check("play_ball_en", 8'(ball_en), 8'd1);

    // Held hit counts once
    for (int i = 0; i < 500; i++) drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    check("held_hit", {score1, score0}, 8'h01);

    // BCD carry 09 -> 10, then on to 12
    for (int i = 0; i < 9; i++) pulse(0, 1, 0);
    check("carry_10", {score1, score0}, 8'h10);
    for (int i = 0; i < 2; i++) pulse(0, 1, 0);
    check("score_12", {score1, score0}, 8'h12);

    // Saturation at 99
    for (int i = 0; i < 87; i++) pulse(0, 1, 0);
    check("score_99", {score1, score0}, 8'h99);
    check("bonus_lives", 8'(lives), 8'(3 + EXTRA));
    pulse(0, 1, 0);
    check("score_sat", {score1, score0}, 8'h99);

    // Lose every life
    for (int i = 1; i <= 3 + EXTRA; i++) begin
      pulse(0, 0, 1);
      check("miss_lives", 8'(lives), 8'(3 + EXTRA - i));
      if (i < 3 + EXTRA) begin
        check("miss_serve", 8'(state), 8'd1);
        frames(SERVE_FRAMES, 1);
        check("miss_replay", 8'(state), 8'd2);
      end
    end
    check("over_state", 8'(state), 8'd3);
    check("over_flag", 8'(game_over), 8'd1);

    // OVER times out to IDLE keeping the score
    frames(OVER_FRAMES - 1, 1);
    check("over_179", 8'(state), 8'd3);
    frames(1, 0);
    check("over_idle", 8'(state), 8'd0);
    check("over_kept", {score1, score0}, 8'h99);

    // Second game: simultaneous hit and miss
    pulse(1, 0, 0);
    frames(SERVE_FRAMES, 0);
    for (int i = 0; i < 5; i++) pulse(0, 1, 0);
    pulse(0, 0, 1);
    check("g2_lives2", 8'(lives), 8'd2);
    frames(SERVE_FRAMES, 0);
    pulse(0, 1, 1);
    check("both_score", {score1, score0}, 8'h06);
    check("both_lives", 8'(lives), 8'd1);
    check("both_state", 8'(state), 8'd1);
    for (int i = 0; i < 3; i++) pulse(0, 1, 0);
    check("serve_hits", {score1, score0}, 8'h06);
    frames(SERVE_FRAMES, 0);
    pulse(1, 0, 0);
    check("play_start_ign", 8'(state), 8'd2);
    pulse(0, 0, 1);
    check("g2_over", 8'(state), 8'd3);
    check("g2_over_lives", 8'(lives), 8'd0);

    // Start in OVER begins a new game
    pulse(1, 0, 0);
    check("over_restart", 8'(state), 8'd1);
    check("restart_score", {score1, score0}, 8'h00);
    check("restart_lives", 8'(lives), 8'd3);
    frames(SERVE_FRAMES, 0);
    for (int i = 0; i < 4; i++) pulse(0, 1, 0);

    // Asynchronous reset mid-PLAY
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check("arst_state", 8'(state), 8'd0);
    check("arst_score", {score1, score0}, 8'h00);
    rst_val = 1'b1;
    drive(0, 1, 0, 0);
    rst_val = 1'b0;
    drive(0, 1, 0, 0);
    check("rel_start", 8'(state), 8'd1);
    drive(0, 0, 0, 0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
